// File: rtl/tff_down_counter.sv
// tff_down_counter
//
// Loadable, start/stop-controlled binary down-counter with a terminal-count
// pulse. It is the count-down counterpart of the 3-bit T-flip-flop up-counter
// and is meant for "wait N cycles, then act" sequencing.
//
// Control is a three-state FSM (IDLE, RUN, PAUSE). Each edge applies the
// priority load > stop > start > decrement.
//
// Ports:
//   clk       in   rising-edge clock
//   nrst      in   asynchronous active-low reset
//   load      in   load request, highest priority; count and reload <= load_val
//   load_val  in   [WIDTH] value captured on load
//   start     in   begin the countdown from IDLE (ignored when count == 0)
//   stop      in   abort the countdown and hold the count
//   en        in   decrement qualifier while running; low pauses the count
//   count     out  [WIDTH] current counter value, registered
//   busy      out  high while in RUN or PAUSE, registered
//   done      out  one-cycle terminal-count pulse, registered
//   zero      out  combinational, count == 0
//
// Optional feature: define TFF_DOWN_COUNTER_AUTO_RELOAD_EN to turn on
// auto-reload. The terminal decrement then reloads the last loaded value and
// stays in RUN, which gives a periodic done. Without the macro, the terminal
// decrement goes to 0 and returns to IDLE, and that build has no reload
// register.

module tff_down_counter #(
  parameter int unsigned WIDTH = 3  // legal 2..16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_busy;
  logic             r_done;

  logic             w_zero;
  logic             w_one;

`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
`endif

  assign w_zero = (r_count == '0);
  assign w_one  = (r_count == WIDTH'(1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= StIdle;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      // done is a single-cycle pulse. It is re-armed only by a terminal decrement.
      r_done <= 1'b0;

      if (load) begin
        // load overrides everything, including a coincident terminal decrement.
        r_count  <= load_val;
`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
        r_reload <= load_val;
`endif
        r_state  <= StIdle;
        r_busy   <= 1'b0;
      end else if (stop) begin
        // stop also masks a coincident start while IDLE; count always holds.
        r_state <= StIdle;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (start && !w_zero) begin
              r_state <= StRun;
              r_busy  <= 1'b1;
            end
          end

          StRun: begin
            if (!en) begin
              r_state <= StPause;
            end else if (w_one) begin
              r_done <= 1'b1;
`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
              r_count <= r_reload;
`else
              r_count <= '0;
              r_state <= StIdle;
              r_busy  <= 1'b0;
`endif
            end else begin
              // In RUN, count >= 1 is guaranteed, so this can never underflow.
              r_count <= r_count - WIDTH'(1);
            end
          end

          StPause: begin
            // The resume edge only returns to RUN. Decrementing resumes on the next edge.
            if (en) begin
              r_state <= StRun;
            end
          end

          default: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;
  assign zero  = w_zero;

endmodule

// File: doc/tff_down_counter.md
Name: tff_down_counter

Overview:
- Loadable, start/stop-controlled binary down-counter. It is the counting-down counterpart of the team's 3-bit T-flip-flop up-counter.
- Provides a countdown timer with a terminal-count pulse, for sequencing blocks that need "wait N cycles then act".
- Control is a small 3-state FSM. The count register is WIDTH bits and decrements by one per enabled cycle.

Parameters:
- WIDTH, 3, width of count, load_val and the reload register (legal 2..16).

Ports:
- clk  input  1  rising-edge clock
- nrst  input  1  asynchronous active-low reset
- load  input  1  load request; highest priority
- load_val  input  WIDTH  value captured on load
- start  input  1  begin countdown from IDLE
- stop  input  1  abort countdown, hold count
- en  input  1  count enable (decrement qualifier while running)
- count  output  WIDTH  current counter value, registered
- busy  output  1  high while state is RUN or PAUSE, registered
- done  output  1  one-cycle terminal-count pulse, registered
- zero  output  1  combinational, count == 0

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low.
  - nrst=0 immediately forces count=0, reload register=0, state=IDLE, busy=0, done=0. zero therefore reads 1.
  - Reset mid-count discards all progress; no done is produced.
- States: IDLE, RUN, PAUSE.
- Per-edge priority: load > stop > start > decrement.
- load=1 (any state):
  - count<=load_val, reload register<=load_val, state<=IDLE, done<=0.
  - A load coinciding with the final decrement suppresses done.
- stop=1 (RUN or PAUSE, no load): state<=IDLE, count holds, done<=0.
- start=1 in IDLE with count!=0:
  - state<=RUN; count unchanged on that edge.
  - start with count==0 is ignored and the block stays IDLE.
  - start in RUN or PAUSE is ignored.
- RUN:
  - en=1 and count>1: count<=count-1.
  - en=0: state<=PAUSE, count holds.
  - en=1 and count==1: count<=0, done<=1 for exactly one cycle, state<=IDLE (see optional feature).
- PAUSE:
  - en=1: state<=RUN, no decrement on that edge.
  - en=0: stay in PAUSE.
- done:
  - Deasserts on the edge after it rises.
  - Never asserts in the same cycle as a load.
- Latency: after load V (V>0), start sampled at edge E, en held high:
  - busy=1 after edge E.
  - count reaches 0 and done=1 after edge E+V.
  - busy=0 after edge E+V.
- Wrap-around: the count never decrements below 0; underflow is impossible by construction.
- busy is 1 exactly when state is RUN or PAUSE.

Optional Feature:
- Macro: TFF_DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - On the terminal decrement (RUN, en=1, count==1): count<=reload register, done<=1 for one cycle, state remains RUN, busy stays 1.
  - The result is a periodic done with period V cycles.
  - stop and load still exit to IDLE as above.
- Undefined:
  - Terminal decrement goes to count=0 and IDLE as in Behaviour.
  - The reload register may be omitted from the implementation.

Test Plan:
- Reset: nrst low mid-run with count=5 → count=0, busy=0, done=0, zero=1 immediately, without waiting for a clock edge.
- Basic countdown (WIDTH=3): load 5, start at edge E, en=1 → count 5,4,3,2,1,0 after edges E..E+5; done=1 only after E+5; busy falls after E+5.
- Pause/resume: load 4, start, en=0 for 3 cycles after the first decrement → count holds at 3 and state is PAUSE. Then en=1 → one resume edge with no decrement, then 2,1,0 with done pulse.
- Priority: on the edge where count==1 in RUN, assert load=1, load_val=7 → count=7, IDLE, done stays 0. Separately, stop at count=2 → count holds 2, busy=0.
- Boundaries: start with count=0 → stays IDLE, busy=0. Load 7 (max for WIDTH=3) and run → 7 decrements to 0 with a single done.
- Auto-reload (macro defined): load 3, start, en=1 for 10 cycles → count sequence 3,2,1,3,2,1,3,..., done every 3rd cycle, busy stays 1; then stop → IDLE.
